hog_frame_scheduler: RTL and testbench

//   Frame-level sequencer for the HOG feature generator. On start, fetches one frame of
//   per-cell 9-bin histograms from the cell histogram RAM in raster order. Drives them into
//   the generator with its forward-address/clear and cell-address sidebands.

---
 rtl/hog_pkg.sv | 20 ++
 rtl/hog_fetch_pipe.sv | 38 +++
 rtl/hog_frame_scheduler.sv | 103 ++++++++++
 tb/tb_hog_frame_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hog_pkg.sv
// hog_pkg: shared geometry, widths and FSM encoding for the HOG frame scheduler
package hog_pkg;
    localparam int HOG_ADDR_W    = 11;
    localparam int HOG_CELL_W    = 40;
    localparam int HOG_CELL_H    = 30;
    localparam int HOG_BIN_I     = 16;
    localparam int HOG_BIN_F     = 16;
    localparam int HOG_BIN_W     = 9 * (HOG_BIN_I + HOG_BIN_F);
    localparam int HOG_RD_LAT    = 1;
    localparam int HOG_DRAIN_MAX = 64;
    localparam int HOG_N         = HOG_CELL_W * HOG_CELL_H;
    localparam int HOG_BLK_N     = (HOG_CELL_W - 1) * (HOG_CELL_H - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    // 2x2-cell blocks overlap by one cell, so a w x h grid yields (w-1)*(h-1) blocks
    function automatic int blk_n(input int w, input int h);
        return (w - 1) * (h - 1);
    endfunction
endpackage

// File: rtl/hog_fetch_pipe.sv
// hog_fetch_pipe: RD_LAT-deep delay line aligning {valid, address} with RAM read data
//   clk, rst (sync, active-low) | in_valid, in_addr: issued read | out_valid, out_addr: read data is valid now
module hog_fetch_pipe #(
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);
    logic [RD_LAT-1:0]             v_q, v_d;
    logic [RD_LAT-1:0][ADDR_W-1:0] a_q, a_d;

    always_comb begin
        v_d[0] = in_valid;
        a_d[0] = in_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            v_d[i] = v_q[i-1];
            a_d[i] = a_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_q <= '0;
            a_q <= '0;
        end else begin
            v_q <= v_d;
            a_q <= a_d;
        end
    end

    assign out_valid = v_q[RD_LAT-1];
    assign out_addr  = a_q[RD_LAT-1];
endmodule

// File: rtl/hog_frame_scheduler.sv
// hog_frame_scheduler: fetches one frame of cell histograms in raster order into the HOG generator
//   clk, rst (sync, active-low); start/cells_ready: frame request; hold: suspends new fetches
//   ram_en/ram_addr/ram_data: histogram RAM read port; gen_valid_fw/gen_addr_fw: forward address (0 clears)
//   gen_valid/gen_address/gen_bin: cell histogram to generator; gen_o_valid: block returned
//   busy, frame_done (pulse), blk_cnt (blocks this frame), err (sticky drain timeout)
module hog_frame_scheduler
    import hog_pkg::*;
#(
    parameter int ADDR_W    = HOG_ADDR_W,
    parameter int CELL_W    = HOG_CELL_W,
    parameter int CELL_H    = HOG_CELL_H,
    parameter int BIN_W     = HOG_BIN_W,
    parameter int RD_LAT    = HOG_RD_LAT,
    parameter int DRAIN_MAX = HOG_DRAIN_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cells_ready,
    input  logic              hold,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [BIN_W-1:0]  ram_data,
    output logic              gen_valid_fw,
    output logic [ADDR_W-1:0] gen_addr_fw,
    output logic              gen_valid,
    output logic [ADDR_W-1:0] gen_address,
    output logic [BIN_W-1:0]  gen_bin,
    input  logic              gen_o_valid,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] blk_cnt,
    output logic              err
);
    localparam int N     = CELL_W * CELL_H;
    localparam int BLK_N = blk_n(CELL_W, CELL_H);
    localparam int TW    = $clog2(DRAIN_MAX + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, blk_cnt_q, blk_cnt_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              err_q, err_d, done_q, done_d;
    logic              accept, last, hit, tout, blk_inc, pipe_v;
    logic [ADDR_W-1:0] pipe_a;

    always_comb begin
        accept    = state_q == IDLE && start && cells_ready;
        // gated by rst so nothing is fetched in the cycle reset is asserted
        ram_en    = rst && state_q == ISSUE && !hold;
        last      = ram_en && cnt_q == ADDR_W'(N - 1);
        hit       = blk_cnt_q == ADDR_W'(BLK_N);
        tout      = tmr_q == TW'(DRAIN_MAX - 1);
        blk_inc   = gen_o_valid && (state_q == ISSUE || state_q == DRAIN) && blk_cnt_q != '1;
        state_d   = accept ? ISSUE :
                    (state_q == ISSUE && last) ? DRAIN :
                    (state_q == DRAIN && (hit || tout)) ? DONE :
                    state_q == DONE ? IDLE : state_q;
        cnt_d     = accept ? '0 : ram_en ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        tmr_d     = state_q == DRAIN ? tmr_q + 1'b1 : '0;
        blk_cnt_d = accept ? '0 : blk_inc ? blk_cnt_q + 1'b1 : blk_cnt_q;
        // a block count match wins over a simultaneous timeout
        err_d     = accept ? 1'b0 : (state_q == DRAIN && tout && !hit) ? 1'b1 : err_q;
        done_d    = state_q == DRAIN && (hit || tout);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            blk_cnt_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            blk_cnt_q <= blk_cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    hog_fetch_pipe #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (ram_en),
        .in_addr  (ram_addr),
        .out_valid(pipe_v),
        .out_addr (pipe_a)
    );

    assign ram_addr     = cnt_q;
    assign gen_valid_fw = ram_en;
    assign gen_addr_fw  = ram_addr;
    assign gen_valid    = rst && pipe_v;
    assign gen_address  = pipe_a;
    assign gen_bin      = ram_data;
    assign busy         = state_q != IDLE;
    assign frame_done   = done_q;
    assign blk_cnt      = blk_cnt_q;
    assign err          = err_q;
endmodule

// File: tb/tb_hog_frame_scheduler.sv
// tb_hog_frame_scheduler: directed scoreboard bench on a 4x3-cell geometry with RD_LAT=2
module tb_hog_frame_scheduler;
  logic         clk = 1'b0;
  logic         rst, start, cells_ready, hold;
  logic         ram_en, gen_valid_fw, gen_valid, busy, frame_done, err;
  logic [10:0]  ram_addr, gen_addr_fw, gen_address, blk_cnt;
  logic [287:0] ram_data, gen_bin;
  logic         gen_o_valid = 1'b0;
  logic [1:0]   rv = '0;
  logic [10:0]  ra [2];
  int           n_cmp = 0, n_bad = 0;
  int           blk_limit = 6, blk_sent = 0;
  logic [10:0]  exp_iss[$], exp_cell[$];

  always #5 clk = ~clk;

  hog_frame_scheduler #(
    .ADDR_W(11), .CELL_W(4), .CELL_H(3), .BIN_W(288), .RD_LAT(2), .DRAIN_MAX(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cells_ready(cells_ready), .hold(hold),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_data(ram_data),
    .gen_valid_fw(gen_valid_fw), .gen_addr_fw(gen_addr_fw),
    .gen_valid(gen_valid), .gen_address(gen_address), .gen_bin(gen_bin),
    .gen_o_valid(gen_o_valid), .busy(busy), .frame_done(frame_done),
    .blk_cnt(blk_cnt), .err(err)
  );

  function automatic logic [287:0] tag(input logic [10:0] a);
    return {9{{21'h15A5A, a}}};
  endfunction

  task automatic chk(input string tg, input logic [287:0] o, input logic [287:0] e);
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tg, o, e);
    end
  endtask

  always @(posedge clk) begin
    rv    <= {rv[0], ram_en};
    ra[0] <= ram_addr;
    ra[1] <= ra[0];
  end
  assign ram_data = rv[1] ? tag(ra[1]) : '0;

  always @(posedge clk) begin
    logic want;
    want = gen_valid && gen_address >= 11'd4 && gen_address[1:0] != 2'd0 && blk_sent < blk_limit;
    gen_o_valid <= want;
    if (gen_valid_fw && gen_addr_fw == 11'd0) blk_sent <= 0;
    else if (want) blk_sent <= blk_sent + 1;
  end

  always @(negedge clk) begin
    logic [10:0] e;
    if (ram_en) begin
      e = exp_iss.size() != 0 ? exp_iss.pop_front() : 11'h7ff;
      chk("ram_addr", ram_addr, e);
      chk("fw_addr", gen_addr_fw, e);
      chk("fw_valid", gen_valid_fw, 1'b1);
      chk("en_under_hold", hold, 1'b0);
    end
    if (gen_valid) begin
      e = exp_cell.size() != 0 ? exp_cell.pop_front() : 11'h7ff;
      chk("gen_address", gen_address, e);
      chk("gen_bin", gen_bin, tag(e));
    end
  end

  task automatic do_start();
    start = 1'b1;
    cells_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      exp_iss.push_back(11'(k));
      exp_cell.push_back(11'(k));
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_idx, input logic [10:0] exp_blk, input logic exp_err);
    int idx = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      idx = c;
      if (frame_done) break;
    end
    chk("done_seen", frame_done, 1'b1);
    if (exp_idx > 0) chk("done_cycle", idx, exp_idx);
    chk("done_blk", blk_cnt, exp_blk);
    chk("done_err", err, exp_err);
    chk("done_busy", busy, 1'b1);
    chk("iss_left", exp_iss.size(), 0);
    chk("cell_left", exp_cell.size(), 0);
    @(negedge clk);
    chk("done_pulse", frame_done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("blk_hold", blk_cnt, exp_blk);
    chk("err_hold", err, exp_err);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b1;
    cells_ready = 1'b1;
    hold = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ram_en", ram_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_gen_valid", gen_valid, 1'b0);
      chk("rst_fw_valid", gen_valid_fw, 1'b0);
      chk("rst_addr", ram_addr, 11'd0);
      chk("rst_done", frame_done, 1'b0);
      chk("rst_blk", blk_cnt, 11'd0);
      chk("rst_err", err, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b0;
    cells_ready = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("nordy_busy", busy, 1'b0);
      chk("nordy_en", ram_en, 1'b0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    cells_ready = 1'b1;
    @(negedge clk);
    chk("nordy_forgot", busy, 1'b0);
    @(posedge clk);
    #1;
    do_start();
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      chk("en_window", ram_en, (i <= 12));
      chk("gv_window", gen_valid, (i >= 3));
      chk("busy_frame", busy, 1'b1);
      if (i == 1) begin
        chk("clear_valid", gen_valid_fw, 1'b1);
        chk("clear_addr", gen_addr_fw, 11'd0);
      end
    end
    wait_done(0, 11'd6, 1'b0);
    @(posedge clk);
    #1;
    do_start();
    repeat (6) @(posedge clk);
    #1;
    hold = 1'b1;
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_en", ram_en, 1'b0);
      chk("hold_busy", busy, 1'b1);
    end
    @(posedge clk);
    #1;
    hold = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("resume_en", ram_en, 1'b1);
    chk("resume_addr", ram_addr, 11'd6);
    wait_done(0, 11'd6, 1'b0);
    @(posedge clk);
    #1;
    blk_limit = 5;
    do_start();
    wait_done(77, 11'd5, 1'b1);
    @(posedge clk);
    #1;
    blk_limit = 6;
    do_start();
    @(negedge clk);
    chk("err_cleared", err, 1'b0);
    chk("restart_busy", busy, 1'b1);
    wait_done(0, 11'd6, 1'b0);
    @(posedge clk);
    #1;
    do_start();
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_iss.delete();
    exp_cell.delete();
    @(negedge clk);
    chk("mid_rst_en", ram_en, 1'b0);
    chk("mid_rst_gv", gen_valid, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_en", ram_en, 1'b0);
    chk("post_rst_gv", gen_valid, 1'b0);
    chk("post_rst_blk", blk_cnt, 11'd0);
    chk("post_rst_done", frame_done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("flush_gv", gen_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    do_start();
    wait_done(0, 11'd6, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
